// File: rtl/hram_req_queue_pkg.sv
// Shared types and constants for the HyperRAM request queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hram_pkg;

    // Controller-side sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_GAP     = 2'd3
    } hrq_state_t;

    // Data returned to the host when a read never completes.
    localparam logic [31:0] HRQ_TMO_DATA = 32'hDEAD_BEEF;

    // One queued host command.
    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } hrq_entry_t;

    function automatic int hrq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hram_req_queue_if.sv
// Host-side and controller-side bus bundle of the request queue.
// Latency: n/a (wires only).
// Backpressure: host side stalls on h_waitrequest; controller side has none.
// slave modport: queue view (takes host requests, drives the controller).
// master modport: environment view (drives host requests, models the controller).
interface hram_req_queue_if;

    // Host port
    logic [31:0] h_address;
    logic        h_read;
    logic        h_write;
    logic [31:0] h_writedata;
    logic        h_waitrequest;
    logic [31:0] h_readdata;
    logic        h_readdatavalid;

    // Controller port
    logic [31:0] m_address;
    logic [31:0] m_writedata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;

    // Sticky error flag
    logic        err;

    modport slave (
        input  h_address, h_read, h_write, h_writedata,
        output h_waitrequest, h_readdata, h_readdatavalid,
        output m_address, m_writedata, m_read, m_write,
        input  m_readdata, m_readdatavalid,
        output err
    );

    modport master (
        output h_address, h_read, h_write, h_writedata,
        input  h_waitrequest, h_readdata, h_readdatavalid,
        input  m_address, m_writedata, m_read, m_write,
        output m_readdata, m_readdatavalid,
        input  err
    );

endinterface

// File: rtl/hram_req_queue_fifo.sv
// Command FIFO: DEPTH entries of hrq_entry_t, pointers carry one wrap bit.
// Latency: a pushed entry is visible at the head on the next cycle; no bypass.
// Backpressure: wr_vld is ignored while full; rd_rdy is ignored while empty.
// Ports: clk, rst (sync, active-low), wr_vld/wr_dat/full, rd_rdy/rd_dat/empty.
module hrq_fifo
    import hram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_vld,
    input  hrq_entry_t wr_dat,
    output logic       full,
    input  logic       rd_rdy,
    output hrq_entry_t rd_dat,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    hrq_entry_t    mem_q [DEPTH];
    hrq_entry_t    mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_vld && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_dat;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_rdy && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/hram_req_queue.sv
// Queues host read/write requests and replays them one at a time as fixed-width
// m_read/m_write pulses with an idle gap so the HyperRAM controller returns to IDLE.
// Latency: accepted read -> h_readdatavalid = 1 + 1 + PULSE_CYC + controller latency + 1.
// Backpressure: h_waitrequest while the command FIFO is full or reset is held.
// Ports: clk, rst (sync, active-low), bus (host h_* / controller m_* / err).
// Build option: define HRQ_TIMEOUT_EN to give up on a read after TMO_CYC cycles
// in WAIT_RD, returning HRQ_TMO_DATA and setting err.
module hram_req_queue
    import hram_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 12,
    parameter int TMO_CYC   = 1024
) (
    input  logic           clk,
    input  logic           rst,
    hram_req_queue_if.slave bus
);

    // One counter serves the pulse, gap and timeout phases.
    localparam int CNT_MAX = hrq_max(hrq_max(PULSE_CYC, GAP_CYC), TMO_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
`ifdef HRQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_CYC - 1);
`endif

    hrq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_read_q, m_read_d;
    logic             m_write_q, m_write_d;
    logic [31:0]      m_address_q, m_address_d;
    logic [31:0]      m_writedata_q, m_writedata_d;
    logic [31:0]      h_readdata_q, h_readdata_d;
    logic             h_readdatavalid_q, h_readdatavalid_d;
    logic             err_q, err_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             host_push;
    hrq_entry_t       push_dat;
    hrq_entry_t       head;

    // Stall during reset so nothing is accepted into a FIFO being cleared.
    assign bus.h_waitrequest = fifo_full || !rst;
    assign host_push         = (bus.h_read || bus.h_write) && !bus.h_waitrequest;

    // A read strobe wins over a simultaneous write; the write data is dropped.
    always_comb begin
        push_dat       = '0;
        push_dat.rd    = bus.h_read;
        push_dat.addr  = bus.h_address;
        push_dat.wdata = bus.h_read ? 32'h0 : bus.h_writedata;
    end

    hrq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (host_push),
        .wr_dat (push_dat),
        .full   (fifo_full),
        .rd_rdy (fifo_pop),
        .rd_dat (head),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        m_read_d          = m_read_q;
        m_write_d         = m_write_q;
        m_address_d       = m_address_q;
        m_writedata_d     = m_writedata_q;
        h_readdata_d      = h_readdata_q;
        h_readdatavalid_d = 1'b0;
        err_d             = err_q;
        fifo_pop          = 1'b0;

        if (host_push && bus.h_read && bus.h_write) begin
            err_d = 1'b1;
        end
        // Read data with no read outstanding is dropped but flagged.
        if (bus.m_readdatavalid && (state_q != ST_WAIT_RD)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    m_address_d   = head.addr;
                    m_writedata_d = head.wdata;
                    // Strobe is raised together with the address so it is
                    // high for the whole of ISSUE.
                    m_read_d      = head.rd;
                    m_write_d     = !head.rd;
                    cnt_d         = '0;
                    state_d       = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (cnt_q == PULSE_LAST) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    cnt_d     = '0;
                    // m_read_q still identifies the command type here.
                    state_d   = m_read_q ? ST_WAIT_RD : ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_RD: begin
                if (bus.m_readdatavalid) begin
                    h_readdata_d      = bus.m_readdata;
                    h_readdatavalid_d = 1'b1;
                    cnt_d             = '0;
                    state_d           = ST_GAP;
                end
`ifdef HRQ_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    h_readdata_d      = HRQ_TMO_DATA;
                    h_readdatavalid_d = 1'b1;
                    err_d             = 1'b1;
                    cnt_d             = '0;
                    state_d           = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset also drops any in-flight command: no read return is produced.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            m_read_q          <= 1'b0;
            m_write_q         <= 1'b0;
            m_address_q       <= '0;
            m_writedata_q     <= '0;
            h_readdata_q      <= '0;
            h_readdatavalid_q <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            m_read_q          <= m_read_d;
            m_write_q         <= m_write_d;
            m_address_q       <= m_address_d;
            m_writedata_q     <= m_writedata_d;
            h_readdata_q      <= h_readdata_d;
            h_readdatavalid_q <= h_readdatavalid_d;
            err_q             <= err_d;
        end
    end

    assign bus.m_read          = m_read_q;
    assign bus.m_write         = m_write_q;
    assign bus.m_address       = m_address_q;
    assign bus.m_writedata     = m_writedata_q;
    assign bus.h_readdata      = h_readdata_q;
    assign bus.h_readdatavalid = h_readdatavalid_q;
    assign bus.err             = err_q;

endmodule

// File: tb/tb_hram_req_queue.sv
// Testbench for hram_req_queue: host driver, controller model, scoreboards.
// Latency: n/a.
// Backpressure: host driver holds a request until h_waitrequest is low.
`timescale 1ns/1ps
module tb_hram_req_queue;
    import hram_pkg::*;

    localparam int DEPTH     = 4;
    localparam int PULSE_CYC = 2;
    localparam int GAP_CYC   = 12;
    localparam int TMO_CYC   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hram_req_queue_if bus();

    hram_req_queue #(
        .DEPTH     (DEPTH),
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC),
        .TMO_CYC   (TMO_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards
    hrq_entry_t  exp_cmd_q[$];
    logic [31:0] exp_rd_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Controller memory contents: 0x100 holds 0x1234_5678.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'h1234_5778;
    endfunction

    // Controller model knobs (written by stimulus only)
    int ctrl_dly  = 20;   // cycles from first m_read-high cycle to data return
    bit no_return = 1'b0;
    int spur_cnt  = 0;

    // Model / monitor state (written by the model only)
    int          spur_done = 0;
    bit          ret_pend  = 1'b0;
    int          ret_at    = 0;
    logic [31:0] ret_dat   = '0;
    logic        prev_rd   = 1'b0;
    logic        prev_wr   = 1'b0;
    int          hi_cnt    = 0;
    int          fall_cyc  = -1;
    int          cmd_cnt   = 0;
    int          rdv_cnt   = 0;
    int          rdv_cyc   = 0;
    logic [31:0] last_rdata = '0;

    always @(negedge clk) begin
        hrq_entry_t e;
        bus.m_readdatavalid = 1'b0;
        bus.m_readdata      = '0;
        if (!rst) begin
            ret_pend = 1'b0;
            prev_rd  = 1'b0;
            prev_wr  = 1'b0;
            hi_cnt   = 0;
            fall_cyc = -1;
        end else begin
            if (ret_pend && (cyc == ret_at)) begin
                bus.m_readdatavalid = 1'b1;
                bus.m_readdata      = ret_dat;
                ret_pend            = 1'b0;
            end
            if (spur_cnt != spur_done) begin
                bus.m_readdatavalid = 1'b1;
                bus.m_readdata      = 32'h5555_AAAA;
                spur_done           = spur_cnt;
            end
            if ((bus.m_read && !prev_rd) || (bus.m_write && !prev_wr)) begin
                cmd_cnt++;
                hi_cnt = 1;
                if (fall_cyc >= 0)
                    check("cmd_gap", 32'((cyc - fall_cyc) >= GAP_CYC), 32'd1);
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexp", 32'({bus.m_read, bus.m_write}), 32'd0);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd_rd", 32'(bus.m_read), 32'(e.rd));
                    check("cmd_wr", 32'(bus.m_write), 32'(!e.rd));
                    check("cmd_addr", bus.m_address, e.addr);
                    if (!e.rd) check("cmd_wdata", bus.m_writedata, e.wdata);
                end
                if (bus.m_read && !no_return) begin
                    ret_pend = 1'b1;
                    ret_at   = cyc + ctrl_dly;
                    ret_dat  = mem_val(bus.m_address);
                end
            end else if (bus.m_read || bus.m_write) begin
                hi_cnt++;
            end else if (prev_rd || prev_wr) begin
                check("pulse_len", hi_cnt, PULSE_CYC);
                fall_cyc = cyc;
            end
            prev_rd = bus.m_read;
            prev_wr = bus.m_write;
        end
        if (bus.h_readdatavalid) begin
            rdv_cnt++;
            rdv_cyc    = cyc;
            last_rdata = bus.h_readdata;
            if (exp_rd_q.size() == 0)
                check("rdv_unexp", 32'(bus.h_readdatavalid), 32'd0);
            else
                check("rd_data", bus.h_readdata, exp_rd_q.pop_front());
        end
    end

    int acc_cyc = 0;

    // Called just after a negedge; returns just after a later negedge.
    task automatic host_req(input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
        int n;
        hrq_entry_t e;
        n = 0;
        bus.h_read      = rd;
        bus.h_write     = wr;
        bus.h_address   = a;
        bus.h_writedata = d;
        while (bus.h_waitrequest && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.h_waitrequest) begin
            check("req_accept_tmo", 32'(bus.h_waitrequest), 32'd0);
        end else begin
            acc_cyc = cyc;
            e.rd    = rd;
            e.addr  = a;
            e.wdata = d;
            exp_cmd_q.push_back(e);
            if (rd) exp_rd_q.push_back(no_return ? HRQ_TMO_DATA : mem_val(a));
        end
        @(negedge clk);
        bus.h_read  = 1'b0;
        bus.h_write = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_cmd_q.size() != 0 || exp_rd_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_cmd_q.size() + exp_rd_q.size()), 32'd0);
        repeat (GAP_CYC + 4) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        exp_cmd_q.delete();
        exp_rd_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base_rdv;
        int base_cmd;
        int a0;
        int n;

        bus.h_address   = '0;
        bus.h_read      = 1'b0;
        bus.h_write     = 1'b0;
        bus.h_writedata = '0;
        rst             = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_waitreq", 32'(bus.h_waitrequest), 32'd1);
        check("rst_m_read", 32'(bus.m_read), 32'd0);
        check("rst_m_write", 32'(bus.m_write), 32'd0);
        check("rst_m_addr", bus.m_address, 32'd0);
        check("rst_m_wdata", bus.m_writedata, 32'd0);
        check("rst_h_rdv", 32'(bus.h_readdatavalid), 32'd0);
        check("rst_h_rdata", bus.h_readdata, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_waitreq", 32'(bus.h_waitrequest), 32'd0);

        // Single read of 0x100
        ctrl_dly = 20;
        base_rdv = rdv_cnt;
        host_req(1'b1, 1'b0, 32'h100, 32'h0);
        a0 = acc_cyc;
        wait_drain(500);
        check("t1_rdv_cnt", 32'(rdv_cnt - base_rdv), 32'd1);
        check("t1_rdata", last_rdata, 32'h1234_5678);
        // FIFO + IDLE + pulse + (controller latency after the pulse) + output register
        check("t1_latency", 32'(rdv_cyc - a0), 32'(1 + 1 + PULSE_CYC + (ctrl_dly - PULSE_CYC) + 1));

        // Five back-to-back writes: FIFO fills while the first write is in its gap
        base_cmd = cmd_cnt;
        for (int i = 0; i < 5; i++)
            host_req(1'b0, 1'b1, 32'(i), 32'hC0DE_0000 + 32'(i));
        check("t2_full_stall", 32'(bus.h_waitrequest), 32'd1);
        wait_drain(500);
        check("t2_cmd_cnt", 32'(cmd_cnt - base_cmd), 32'd5);
        check("t2_wr_free", 32'(bus.h_waitrequest), 32'd0);

        // Interleaved read / write / read
        ctrl_dly = 6;
        base_rdv = rdv_cnt;
        host_req(1'b1, 1'b0, 32'h10, 32'h0);
        host_req(1'b0, 1'b1, 32'h14, 32'hA5A5_A5A5);
        host_req(1'b1, 1'b0, 32'h18, 32'h0);
        wait_drain(500);
        check("t3_rdv_cnt", 32'(rdv_cnt - base_rdv), 32'd2);
        check("t3_rdata_last", last_rdata, mem_val(32'h18));
        check("t3_err_clean", 32'(bus.err), 32'd0);

        // Reset while a read waits for data, with writes still queued
        ctrl_dly = 300;
        base_rdv = rdv_cnt;
        base_cmd = cmd_cnt;
        host_req(1'b1, 1'b0, 32'h20, 32'h0);
        host_req(1'b0, 1'b1, 32'h24, 32'h1111_1111);
        host_req(1'b0, 1'b1, 32'h28, 32'h2222_2222);
        n = 0;
        while (cmd_cnt == base_cmd && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_read_issued", 32'(cmd_cnt - base_cmd), 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        exp_cmd_q.delete();
        exp_rd_q.delete();
        base_cmd = cmd_cnt;
        @(negedge clk);
        check("t4_waitreq", 32'(bus.h_waitrequest), 32'd1);
        check("t4_m_read", 32'(bus.m_read), 32'd0);
        check("t4_m_write", 32'(bus.m_write), 32'd0);
        check("t4_m_addr", bus.m_address, 32'd0);
        check("t4_m_wdata", bus.m_writedata, 32'd0);
        check("t4_h_rdv", 32'(bus.h_readdatavalid), 32'd0);
        check("t4_h_rdata", bus.h_readdata, 32'd0);
        check("t4_err", 32'(bus.err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rel_waitreq", 32'(bus.h_waitrequest), 32'd0);
        repeat (40) @(negedge clk);
        check("t4_fifo_empty", 32'(cmd_cnt - base_cmd), 32'd0);
        check("t4_no_rdv", 32'(rdv_cnt - base_rdv), 32'd0);

        // Simultaneous read and write: queued as a read, err set
        ctrl_dly = 8;
        check("t5_err_before", 32'(bus.err), 32'd0);
        host_req(1'b1, 1'b1, 32'h30, 32'hFFFF_FFFF);
        wait_drain(500);
        check("t5_rw_err", 32'(bus.err), 32'd1);
        check("t5_rdata", last_rdata, mem_val(32'h30));

        // Read data while idle is ignored but flagged
        pulse_reset();
        check("t6_err_cleared", 32'(bus.err), 32'd0);
        base_rdv = rdv_cnt;
        spur_cnt++;
        repeat (3) @(negedge clk);
        check("t6_spur_err", 32'(bus.err), 32'd1);
        check("t6_spur_no_rdv", 32'(rdv_cnt - base_rdv), 32'd0);

`ifdef HRQ_TIMEOUT_EN
        // Controller never answers: timeout data returned, err set
        pulse_reset();
        no_return = 1'b1;
        base_rdv  = rdv_cnt;
        host_req(1'b1, 1'b0, 32'h40, 32'h0);
        wait_drain(TMO_CYC + 200);
        check("t7_tmo_rdv", 32'(rdv_cnt - base_rdv), 32'd1);
        check("t7_tmo_data", last_rdata, 32'hDEAD_BEEF);
        check("t7_tmo_err", 32'(bus.err), 32'd1);
        no_return = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hram_req_queue.md
HRAM_REQ_QUEUE -- requirements
Module: hram_req_queue

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries (power of 2, 2..16).
REQ-002 Parameter PULSE_CYC, default 2: cycles m_read/m_write is held high per command.
REQ-003 Parameter GAP_CYC, default 12: minimum idle cycles between commands so the controller returns to IDLE.
REQ-004 Parameter TMO_CYC, default 1024: read-completion timeout, used only under HRQ_TIMEOUT_EN.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 h_address  in  32  host word address.
REQ-008 h_read / h_write  in  1 each  host request strobes.
REQ-009 h_writedata  in  32  host write data.
REQ-010 h_waitrequest  out  1  host stall.
REQ-011 h_readdata  out  32  returned read data.
REQ-012 h_readdatavalid  out  1  one-cycle read-return strobe.
REQ-013 m_address, m_writedata  out  32 each  to controller s0_address and s0_writedata.
REQ-014 m_read / m_write  out  1 each  to controller s0_read and s0_write.
REQ-015 m_readdata  in  32, m_readdatavalid  in  1  from the controller.
REQ-016 err  out  1  sticky error flag.

Function
REQ-017 A host request is accepted when (h_read|h_write) && !h_waitrequest; {rd, address, writedata} is pushed into the FIFO.
REQ-018 h_waitrequest = FIFO full; a push and a pop in the same cycle while full is not permitted; the stall holds.
REQ-019 Simultaneous h_read and h_write is queued as a read; write data is discarded and err is set.
REQ-020 FSM states: IDLE, ISSUE, WAIT_RD, GAP.
REQ-021 IDLE: if the FIFO is non-empty, pop the head, register m_address and m_writedata, and go to ISSUE next cycle.
REQ-022 ISSUE: drive m_read (rd) or m_write (!rd) high for exactly PULSE_CYC cycles with m_address and m_writedata stable; then go to WAIT_RD for a read, or GAP for a write.
REQ-023 WAIT_RD: on m_readdatavalid, register m_readdata into h_readdata, pulse h_readdatavalid one cycle later, then go to GAP.
REQ-024 GAP: hold m_read and m_write low for GAP_CYC cycles, then go to IDLE; m_readdatavalid outside WAIT_RD is ignored and sets err.
REQ-025 Only one command is ever outstanding; read returns are in host issue order.
REQ-026 FIFO pointers wrap modulo DEPTH; the full/empty distinction uses one extra pointer bit.
REQ-027 Minimum latency from accepted read to h_readdatavalid: 1 (FIFO) + 1 (IDLE) + PULSE_CYC + controller latency + 1 cycles.

Reset
REQ-028 While rst=0: FIFO is emptied, FSM is in IDLE, counters are 0, m_read=m_write=0, m_address=m_writedata=0, h_readdatavalid=0, h_readdata=0, err=0, h_waitrequest=1.
REQ-029 h_waitrequest deasserts on the first cycle after rst rises.
REQ-030 Reset during ISSUE or WAIT_RD drops the in-flight command with no h_readdatavalid.

Configuration
REQ-031 Macro HRQ_TIMEOUT_EN defined: in WAIT_RD a counter counts to TMO_CYC; on expiry it returns h_readdata=32'hDEAD_BEEF with an h_readdatavalid pulse, sets err, and enters GAP.
REQ-032 HRQ_TIMEOUT_EN undefined: no counter; WAIT_RD waits indefinitely.

Structure
REQ-033 Package hram_pkg holds the state enum type, the 32'hDEAD_BEEF constant, and the FIFO entry struct {rd, addr[31:0], wdata[31:0]}.
REQ-034 The FIFO is a sub-module hrq_fifo (storage, pointers, full/empty); the FSM stays in hram_req_queue.

Verification
REQ-035 Single read of 0x100 with the controller model returning 0x1234_5678 after 20 cycles -> exactly one h_readdatavalid with 0x1234_5678; m_read high for 2 cycles.
REQ-036 Back-to-back writes to 0x0..0x4 (5 writes) with DEPTH=4 -> h_waitrequest=1 while the FIFO is full, all 5 m_write pulses issued in order, and >=12 idle cycles between pulses.
REQ-037 Interleaved R(0x10), W(0x14, 0xA5A5_A5A5), R(0x18) -> controller sees commands in that order; two read returns in order.
REQ-038 rst=0 asserted mid-WAIT_RD -> no h_readdatavalid, all outputs at reset values on the next cycle, and the FIFO is empty.
REQ-039 With HRQ_TIMEOUT_EN and the controller never returning data -> h_readdata=32'hDEAD_BEEF after TMO_CYC cycles, and err=1.
